wide_adder_sequencer: RTL and testbench

//  Upstream operand sequencer for the 16-bit look-ahead carry generator. Accepts one

---
 rtl/wide_adder_sequencer.sv | 99 +++++++++
 tb/tb_wide_adder_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/wide_adder_sequencer.sv
// rtl/wide_adder_sequencer.sv - slices a wide add into 16-bit steps through one external adder
module wide_adder_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                Clock_In,
  input  logic                Reset_In,
  input  logic                Start_In,
  input  logic [16*WORDS-1:0] Data_A_In,
  input  logic [16*WORDS-1:0] Data_B_In,
  input  logic                Carry_In,
  output logic                Busy_Out,
  output logic                Done_Out,
  output logic [16*WORDS-1:0] Sum_Out,
  output logic                Carry_Out,
  output logic                Overflow_Out,
  output logic [15:0]         Slice_A_Out,
  output logic [15:0]         Slice_B_Out,
  output logic                Slice_Carry_Out,
  input  logic [15:0]         Slice_Sum_In,
  input  logic                Slice_Carry_In
);

  localparam int W  = 16 * WORDS;
  localparam int IW = $clog2(WORDS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          carry_q;
  logic [IW-1:0] idx;
  logic          last;

  assign last = (idx == IW'(WORDS - 1));

  // The external adder is combinational, so slices are steered straight from the latched operands.
  always_comb begin
    Slice_A_Out     = '0;
    Slice_B_Out     = '0;
    Slice_Carry_Out = 1'b0;
    if (state == RUN) begin
      Slice_Carry_Out = carry_q;
      for (int j = 0; j < WORDS; j++) begin
        if (idx == IW'(j)) begin
          Slice_A_Out = a_q[16*j +: 16];
          Slice_B_Out = b_q[16*j +: 16];
        end
      end
    end
  end

  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state        <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      carry_q      <= 1'b0;
      idx          <= '0;
      Busy_Out     <= 1'b0;
      Done_Out     <= 1'b0;
      Sum_Out      <= '0;
      Carry_Out    <= 1'b0;
      Overflow_Out <= 1'b0;
    end else begin
      Done_Out <= 1'b0;
      case (state)
        RUN: begin
          for (int j = 0; j < WORDS; j++) begin
            if (idx == IW'(j)) Sum_Out[16*j +: 16] <= Slice_Sum_In;
          end
          carry_q <= Slice_Carry_In;
          idx     <= idx + 1'b1;
          if (last) begin
            state        <= DONE;
            Busy_Out     <= 1'b0;
            Done_Out     <= 1'b1;
            Carry_Out    <= Slice_Carry_In;
            Overflow_Out <= (a_q[W-1] == b_q[W-1]) && (Slice_Sum_In[15] != a_q[W-1]);
          end
        end
        // IDLE and DONE both accept a new request; results are left to be overwritten slice by slice.
        default: begin
          if (Start_In) begin
            state    <= RUN;
            a_q      <= Data_A_In;
            b_q      <= Data_B_In;
            carry_q  <= Carry_In;
            idx      <= '0;
            Busy_Out <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wide_adder_sequencer.sv
// tb/tb_wide_adder_sequencer.sv - bench for wide_adder_sequencer with 64-bit and 32-bit instances
module tb_wide_adder_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, cin;
  logic [63:0] a, b;
  logic        busy, done, co, ovf;
  logic [63:0] sum;
  logic [15:0] sa, sb, ss;
  logic        sc, sco;

  logic        start2, cin2;
  logic [31:0] a2, b2;
  logic        busy2, done2, co2, ovf2;
  logic [31:0] sum2;
  logic [15:0] sa2, sb2, ss2;
  logic        sc2, sco2;

  // Slice adders standing in for the 16-bit CLA.
  assign {sco, ss}   = {1'b0, sa} + {1'b0, sb} + {16'd0, sc};
  assign {sco2, ss2} = {1'b0, sa2} + {1'b0, sb2} + {16'd0, sc2};

  wide_adder_sequencer #(.WORDS(4)) dut4 (
    .Clock_In(clk), .Reset_In(rst), .Start_In(start),
    .Data_A_In(a), .Data_B_In(b), .Carry_In(cin),
    .Busy_Out(busy), .Done_Out(done), .Sum_Out(sum), .Carry_Out(co), .Overflow_Out(ovf),
    .Slice_A_Out(sa), .Slice_B_Out(sb), .Slice_Carry_Out(sc),
    .Slice_Sum_In(ss), .Slice_Carry_In(sco)
  );

  wide_adder_sequencer #(.WORDS(2)) dut2 (
    .Clock_In(clk), .Reset_In(rst), .Start_In(start2),
    .Data_A_In(a2), .Data_B_In(b2), .Carry_In(cin2),
    .Busy_Out(busy2), .Done_Out(done2), .Sum_Out(sum2), .Carry_Out(co2), .Overflow_Out(ovf2),
    .Slice_A_Out(sa2), .Slice_B_Out(sb2), .Slice_Carry_Out(sc2),
    .Slice_Sum_In(ss2), .Slice_Carry_In(sco2)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic check_en = 1'b0;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Reference model for the 64-bit instance: remaining RUN cycles plus the exact wide sum.
  int          rem = 0;
  logic [64:0] m_pend;
  logic        m_pend_ovf;
  logic [63:0] m_sum = '0;
  logic        m_co = 1'b0, m_ovf = 1'b0, m_done = 1'b0;
  logic [63:0] m_a = '0, m_b = '0;
  logic        m_cin = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      rem = 0; m_done = 1'b0; m_sum = '0; m_co = 1'b0; m_ovf = 1'b0;
    end else begin
      m_done = (rem == 1);
      if (rem == 1) begin
        m_sum = m_pend[63:0]; m_co = m_pend[64]; m_ovf = m_pend_ovf;
      end
      if (rem > 0) rem--;
      else if (start) begin
        rem = 4; m_a = a; m_b = b; m_cin = cin;
        m_pend = {1'b0, a} + {1'b0, b} + {64'd0, cin};
        m_pend_ovf = (a[63] == b[63]) && (m_pend[63] != a[63]);
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("busy", busy, rem > 0);
      chk("done", done, m_done);
      if (rem == 0) begin
        chk("sum", sum, m_sum);
        chk("carry", co, m_co);
        chk("ovf", ovf, m_ovf);
        chk("slice_idle", {sa, sb, sc}, 0);
      end else begin
        int k;
        logic [64:0] msk, lo;
        k = 4 - rem;
        msk = (65'd1 << (16 * k)) - 65'd1;
        lo = ({1'b0, m_a} & msk) + ({1'b0, m_b} & msk) + {64'd0, m_cin};
        chk("slice_a", sa, m_a[16*k +: 16]);
        chk("slice_b", sb, m_b[16*k +: 16]);
        chk("slice_c", sc, lo[16*k]);
      end
    end
  end

  task automatic run_add(input logic [63:0] av, input logic [63:0] bv, input logic c,
                         output int lat);
    @(negedge clk);
    a = av; b = bv; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~av; b = ~bv; cin = ~c;
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int lat, ndone, n, prev;
  logic [32:0] ref2;
  logic        ref2_ovf;

  initial begin
    rst = 1'b1; start = 1'b1; a = '1; b = '1; cin = 1'b1;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_outs", {done, sum, co, ovf, sa, sb, sc}, 0);
    start = 1'b0; rst = 1'b0; a = '0; b = '0; cin = 1'b0;
    check_en = 1'b1;

    run_add(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, lat);
    chk("t1_lat", lat, 5);
    chk("t1_sum", sum, 64'h0);
    chk("t1_co_ovf", {co, ovf}, 2'b10);

    run_add(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
    chk("t2_sum", sum, 64'h8000_0000_0000_0000);
    chk("t2_co_ovf", {co, ovf}, 2'b01);

    @(negedge clk);
    a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FED_CBA9_8765_4321; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 64'hDEAD_BEEF_0000_0001; b = 64'h5555_5555_5555_5555;
    repeat (4) @(posedge clk);
    #1; start = 1'b0;
    chk("t3_done", done, 1);
    chk("t3_sum", sum, 64'h2222_2222_2222_2211);
    chk("t3_co", co, 0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("t3_extra_done", ndone, 0);

    @(negedge clk);
    a = 64'h0001_0002_0003_0004; b = 64'h0010_0020_0030_0040; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("t4_outs", {busy, done, sum, co, ovf, sa, sb, sc}, 0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("t4_no_done", ndone, 0);
    run_add(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b1, lat);
    chk("t4_lat", lat, 5);
    chk("t4_sum", sum, 64'h0011_0022_0033_0045);

    a = 64'd1; b = 64'd2; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("t5_busy", busy, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("t5_done", done, 1);
    chk("t5_sum", sum, 64'd3);

    check_en = 1'b0;
    prev = 0;
    for (int i = 0; i < 500; i++) begin
      a2 = $random; b2 = $random; cin2 = 1'($urandom_range(1));
      ref2 = {1'b0, a2} + {1'b0, b2} + {32'd0, cin2};
      ref2_ovf = (a2[31] == b2[31]) && (ref2[31] != a2[31]);
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      n = 0;
      while (!done2 && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      chk("t6_result", {ovf2, co2, sum2}, {ref2_ovf, ref2});
      if (i > 0) chk("t6_spacing", cyc - prev, 3);
      prev = cyc;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
